// File: rtl/cpu_dma_queue_stats_regs.sv
// CPU DMA queue statistics block: event counters, control and sticky overflow
// flags behind a simple req/ack register bus.
module cpu_dma_queue_stats_regs #(
    parameter int NUM_COUNTERS   = 4,
    parameter int CNT_WIDTH      = 32,
    parameter bit SATURATE       = 1'b0,
    parameter int REG_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_COUNTERS-1:0]   event_in,
    input  logic                      reg_req,
    input  logic                      reg_rd_wr_L,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]               reg_wr_data,
    output logic [31:0]               reg_rd_data,
    output logic                      reg_ack
);

    localparam int N = NUM_COUNTERS;
    localparam logic [31:0] CTRL_ADDR = 32'(N);
    localparam logic [31:0] OVF_ADDR  = 32'(N + 1);

    logic [N-1:0][CNT_WIDTH-1:0] cnt;
    logic [N-1:0][CNT_WIDTH-1:0] cnt_nxt;
    logic [1:0]                  ctrl;
    logic [1:0]                  ctrl_nxt;
    logic [N-1:0]                ovf;
    logic [N-1:0]                ovf_nxt;
    logic [N-1:0]                ovf_set;
    logic [N-1:0]                ovf_clr;
    logic                        reg_req_d1;
    logic                        new_req;
    logic                        rd;
    logic                        wr;
    logic                        inc;
    logic [31:0]                 addr;
    logic [31:0]                 rd_nxt;

    always_comb begin
        new_req  = reg_req & ~reg_req_d1;
        rd       = new_req & reg_rd_wr_L;
        wr       = new_req & ~reg_rd_wr_L;
        addr     = 32'(reg_addr);
        cnt_nxt  = cnt;
        ctrl_nxt = ctrl;
        ovf_set  = '0;
        ovf_clr  = '0;
        rd_nxt   = reg_rd_data;
        inc      = 1'b0;

        for (int i = 0; i < N; i++) begin
            inc = event_in[i] & ~ctrl[1];
            if (inc) begin
                if (&cnt[i]) begin
                    ovf_set[i] = 1'b1;
                    cnt_nxt[i] = SATURATE ? cnt[i] : '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
                end
            end
            if (rd && addr == 32'(i)) begin
                rd_nxt = 32'(cnt[i]);
                // Clearing read restarts the count; a same-cycle event lands in it.
                if (ctrl[0]) begin
                    cnt_nxt[i] = inc ? CNT_WIDTH'(1) : '0;
                    ovf_set[i] = 1'b0;
                end
            end
            // A bus write owns the counter; the colliding event is dropped.
            if (wr && addr == 32'(i)) begin
                cnt_nxt[i] = reg_wr_data[CNT_WIDTH-1:0];
                ovf_set[i] = 1'b0;
            end
        end

        if (rd && addr == CTRL_ADDR) rd_nxt = {30'b0, ctrl};
        if (wr && addr == CTRL_ADDR) ctrl_nxt = reg_wr_data[1:0];
        if (rd && addr == OVF_ADDR) rd_nxt = 32'(ovf);
        if (wr && addr == OVF_ADDR) ovf_clr = reg_wr_data[N-1:0];
        if (rd && addr > OVF_ADDR) rd_nxt = 32'hDEAD_BEEF;

        ovf_nxt = (ovf & ~ovf_clr) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            ctrl        <= '0;
            ovf         <= '0;
            reg_rd_data <= '0;
            reg_ack     <= 1'b0;
            reg_req_d1  <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            ctrl        <= ctrl_nxt;
            ovf         <= ovf_nxt;
            reg_rd_data <= rd_nxt;
            reg_ack     <= new_req;
            reg_req_d1  <= reg_req;
        end
    end

endmodule

// File: tb/tb_cpu_dma_queue_stats_regs.sv
// Directed bench for the DMA queue stats block: a 32-bit wrapping instance
// plus 4-bit wrapping and saturating instances sharing the register bus.
module tb_cpu_dma_queue_stats_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_req;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  ev;
    logic [3:0]  ev_s;
    logic [31:0] rd_m, rd_w, rd_s;
    logic        ack_m, ack_w, ack_s;
    int          total = 0;
    int          bad = 0;
    int          n;

    always #5 clk = ~clk;

    cpu_dma_queue_stats_regs #(
        .NUM_COUNTERS(4), .CNT_WIDTH(32), .SATURATE(1'b0), .REG_ADDR_WIDTH(8)
    ) u_main (
        .clk(clk), .reset(reset), .event_in(ev), .reg_req(reg_req),
        .reg_rd_wr_L(rw), .reg_addr(addr), .reg_wr_data(wdata),
        .reg_rd_data(rd_m), .reg_ack(ack_m)
    );

    cpu_dma_queue_stats_regs #(
        .NUM_COUNTERS(4), .CNT_WIDTH(4), .SATURATE(1'b0), .REG_ADDR_WIDTH(8)
    ) u_wrap (
        .clk(clk), .reset(reset), .event_in(ev_s), .reg_req(reg_req),
        .reg_rd_wr_L(rw), .reg_addr(addr), .reg_wr_data(wdata),
        .reg_rd_data(rd_w), .reg_ack(ack_w)
    );

    cpu_dma_queue_stats_regs #(
        .NUM_COUNTERS(4), .CNT_WIDTH(4), .SATURATE(1'b1), .REG_ADDR_WIDTH(8)
    ) u_sat (
        .clk(clk), .reset(reset), .event_in(ev_s), .reg_req(reg_req),
        .reg_rd_wr_L(rw), .reg_addr(addr), .reg_wr_data(wdata),
        .reg_rd_data(rd_s), .reg_ack(ack_s)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic acc(input logic r, input logic [7:0] a,
                       input logic [31:0] wd, input logic [3:0] e);
        @(negedge clk);
        reg_req = 1'b1; rw = r; addr = a; wdata = wd; ev = e;
        @(negedge clk);
        chk("ack", {31'b0, ack_m}, 32'd1);
        reg_req = 1'b0; ev = '0;
        @(negedge clk);
        chk("ack_low", {31'b0, ack_m}, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [7:0] a,
                      input logic [31:0] exp);
        acc(1'b1, a, 32'd0, 4'd0);
        chk(tag, rd_m, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        acc(1'b0, a, d, 4'd0);
    endtask

    task automatic pulse(input logic [3:0] m, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            @(negedge clk); ev = m;
            @(negedge clk); ev = '0;
        end
    endtask

    task automatic pulse_s(input logic [3:0] m, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            @(negedge clk); ev_s = m;
            @(negedge clk); ev_s = '0;
        end
    endtask

    initial begin
        reset = 1'b1; reg_req = 1'b0; rw = 1'b1; addr = '0;
        wdata = '0; ev = '0; ev_s = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ack", {31'b0, ack_m}, 32'd0);
        chk("rst_rd", rd_m, 32'd0);

        // reset map and bad address
        for (int a = 0; a < 6; a++) rd("rst_map", 8'(a), 32'd0);
        rd("bad_addr", 8'd6, 32'hDEAD_BEEF);
        rd("bad_addr_hi", 8'd255, 32'hDEAD_BEEF);

        // five events, then a held request acks once
        pulse(4'b0010, 5);
        rd("ctr1_5", 8'd1, 32'd5);
        @(negedge clk);
        reg_req = 1'b1; rw = 1'b1; addr = 8'd1; n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack_m) n++;
            if (k == 3) reg_req = 1'b0;
        end
        chk("hold_acks", 32'(n), 32'd1);
        chk("hold_data", rd_m, 32'd5);

        // 4-bit wrap vs saturate after 17 events
        pulse_s(4'b0001, 17);
        acc(1'b1, 8'd0, 32'd0, 4'd0);
        chk("wrap_ctr", rd_w, 32'd1);
        chk("sat_ctr", rd_s, 32'hF);
        acc(1'b1, 8'd5, 32'd0, 4'd0);
        chk("wrap_ovf", rd_w, 32'd1);
        chk("sat_ovf", rd_s, 32'd1);

        // clear-on-read with a same-cycle event
        wr(8'd4, 32'd1);
        rd("ctrl_cor", 8'd4, 32'd1);
        pulse(4'b0001, 3);
        acc(1'b1, 8'd0, 32'd0, 4'b0001);
        chk("cor_first", rd_m, 32'd3);
        rd("cor_second", 8'd0, 32'd1);
        rd("cor_third", 8'd0, 32'd0);
        rd("cor_ovf", 8'd5, 32'd0);

        // freeze drops events; OVF write-1-to-clear
        wr(8'd4, 32'hFFFF_FFFE);
        rd("ctrl_frz", 8'd4, 32'd2);
        pulse(4'b0010, 10);
        rd("frz_ctr1", 8'd1, 32'd5);
        wr(8'd4, 32'd0);
        wr(8'd5, 32'd1);
        acc(1'b1, 8'd5, 32'd0, 4'd0);
        chk("w1c_wrap", rd_w, 32'd0);
        chk("w1c_sat_kept", rd_s, 32'd0);

        // 32-bit overflow, and set beats clear
        wr(8'd3, 32'hFFFF_FFFF);
        pulse(4'b1000, 1);
        rd("ovf32_ctr", 8'd3, 32'd0);
        rd("ovf32_flag", 8'd5, 32'd8);
        wr(8'd5, 32'd8);
        rd("ovf32_clr", 8'd5, 32'd0);
        wr(8'd3, 32'hFFFF_FFFF);
        acc(1'b0, 8'd5, 32'd8, 4'b1000);
        rd("set_wins", 8'd5, 32'd8);

        // write beats event; write ack leaves rd_data alone
        acc(1'b0, 8'd2, 32'h10, 4'b0100);
        rd("wr_wins", 8'd2, 32'h10);
        wr(8'd6, 32'h1234);
        chk("wr_keeps_rd", rd_m, 32'h10);
        rd("bad_wr_ign", 8'd4, 32'd0);

        // parallel counting, then reset mid-count with request held
        wr(8'd0, 32'd7);
        pulse(4'b1111, 2);
        rd("par_c0", 8'd0, 32'd9);
        rd("par_c1", 8'd1, 32'd7);
        rd("par_c2", 8'd2, 32'h12);
        wr(8'd4, 32'd1);
        @(negedge clk); ev = 4'hF;
        @(negedge clk);
        reset = 1'b1; reg_req = 1'b1; rw = 1'b1; addr = 8'd6;
        @(negedge clk);
        chk("rst_mid_ack", {31'b0, ack_m}, 32'd0);
        chk("rst_mid_rd", rd_m, 32'd0);
        reset = 1'b0; ev = '0;
        @(negedge clk);
        chk("rst_req_ack", {31'b0, ack_m}, 32'd1);
        chk("rst_req_rd", rd_m, 32'hDEAD_BEEF);
        reg_req = 1'b0;
        @(negedge clk);
        chk("rst_req_once", {31'b0, ack_m}, 32'd0);
        for (int a = 0; a < 6; a++) rd("post_rst", 8'(a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
